// File: rtl/alarm_controller_if.sv
// Alarm controller signal bundle: tick/arm/match/button inputs and sequencer outputs.
interface alarm_controller_if #(
  parameter int CNT_W = 9
);
  logic             tick_1hz;
  logic             arm;
  logic             match;
  logic             snooze;
  logic             stop;
  logic             alarm_enable;
  logic             buzzer;
  logic             ringing;
  logic             snoozing;
  logic [1:0]       snooze_count;
  logic [CNT_W-1:0] remaining;

  modport master (
    output tick_1hz, arm, match, snooze, stop,
    input  alarm_enable, buzzer, ringing, snoozing, snooze_count, remaining
  );

  modport slave (
    input  tick_1hz, arm, match, snooze, stop,
    output alarm_enable, buzzer, ringing, snoozing, snooze_count, remaining
  );
endinterface

// File: rtl/alarm_controller.sv
// Alarm sequencer: arm/holdoff/ring/snooze/stop cycle with 1 s beep pattern.
// All outputs registered from next state; button presses and match act 1 cycle later.
module alarm_controller #(
  parameter int SNOOZE_SEC       = 300,
  parameter int RING_TIMEOUT_SEC = 60,
  parameter int MAX_SNOOZE       = 3,
  parameter int CNT_W            = 9
) (
  input  logic              clk_i,
  input  logic              reset_i,
  alarm_controller_if.slave bus
);

  typedef enum logic [2:0] {
    DISARMED = 3'd0,
    HOLDOFF  = 3'd1,
    ARMED    = 3'd2,
    RINGING  = 3'd3,
    SNOOZE   = 3'd4
  } state_t;

  localparam logic [CNT_W-1:0] RING_LAST  = CNT_W'(RING_TIMEOUT_SEC - 1);
  localparam logic [CNT_W-1:0] RING_MAX   = CNT_W'(RING_TIMEOUT_SEC);
  localparam logic [CNT_W-1:0] SNOOZE_LD  = CNT_W'(SNOOZE_SEC);
  localparam logic [1:0]       SNOOZE_CAP = 2'(MAX_SNOOZE);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] ring_cnt_q, ring_cnt_d;
  logic [CNT_W-1:0] remaining_q, remaining_d;
  logic [1:0]       snz_cnt_q, snz_cnt_d;
  logic             phase_q, phase_d;
  logic             snz_btn_q, stop_btn_q;
  logic             alarm_enable_q, buzzer_q, ringing_q, snoozing_q;

  logic snz_press, stop_press, snz_left, timeout;

  assign snz_press  = bus.snooze & ~snz_btn_q;
  assign stop_press = bus.stop & ~stop_btn_q;
  assign snz_left   = (snz_cnt_q < SNOOZE_CAP);
  assign timeout    = bus.tick_1hz && (ring_cnt_q == RING_LAST);

  always_comb begin
    state_d     = state_q;
    ring_cnt_d  = ring_cnt_q;
    remaining_d = remaining_q;
    snz_cnt_d   = snz_cnt_q;
    phase_d     = phase_q;
    if (!bus.arm) begin
      state_d     = DISARMED;
      ring_cnt_d  = '0;
      remaining_d = '0;
      snz_cnt_d   = '0;
      phase_d     = 1'b0;
    end else begin
      unique case (state_q)
        DISARMED: begin
          state_d   = HOLDOFF;
          snz_cnt_d = '0;
        end
        // Waiting for a tick guarantees the matched second has passed.
        HOLDOFF: begin
          snz_cnt_d = '0;
          if (bus.tick_1hz) state_d = ARMED;
        end
        ARMED: begin
          if (bus.match) begin
            state_d    = RINGING;
            ring_cnt_d = '0;
            phase_d    = 1'b1;
          end
        end
        RINGING: begin
          if (stop_press) begin
            state_d   = HOLDOFF;
            snz_cnt_d = '0;
            phase_d   = 1'b0;
          end else if ((snz_press || timeout) && snz_left) begin
            state_d     = SNOOZE;
            snz_cnt_d   = snz_cnt_q + 2'd1;
            remaining_d = SNOOZE_LD;
            phase_d     = 1'b0;
          end else if (timeout) begin
            state_d   = HOLDOFF;
            snz_cnt_d = '0;
            phase_d   = 1'b0;
          end else if (bus.tick_1hz) begin
            phase_d = ~phase_q;
            if (ring_cnt_q != RING_MAX) ring_cnt_d = ring_cnt_q + CNT_W'(1);
          end
        end
        SNOOZE: begin
          if (stop_press) begin
            state_d     = HOLDOFF;
            remaining_d = '0;
            snz_cnt_d   = '0;
          end else if (bus.tick_1hz) begin
            if (remaining_q == CNT_W'(1)) begin
              state_d     = RINGING;
              remaining_d = '0;
              ring_cnt_d  = '0;
              phase_d     = 1'b1;
            end else if (remaining_q != '0) begin
              remaining_d = remaining_q - CNT_W'(1);
            end
          end
        end
        default: state_d = DISARMED;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q        <= DISARMED;
      ring_cnt_q     <= '0;
      remaining_q    <= '0;
      snz_cnt_q      <= '0;
      phase_q        <= 1'b0;
      snz_btn_q      <= 1'b0;
      stop_btn_q     <= 1'b0;
      alarm_enable_q <= 1'b0;
      buzzer_q       <= 1'b0;
      ringing_q      <= 1'b0;
      snoozing_q     <= 1'b0;
    end else begin
      state_q        <= state_d;
      ring_cnt_q     <= ring_cnt_d;
      remaining_q    <= remaining_d;
      snz_cnt_q      <= snz_cnt_d;
      phase_q        <= phase_d;
      snz_btn_q      <= bus.snooze;
      stop_btn_q     <= bus.stop;
      alarm_enable_q <= (state_d == ARMED) || (state_d == RINGING);
      buzzer_q       <= (state_d == RINGING) && phase_d;
      ringing_q      <= (state_d == RINGING);
      snoozing_q     <= (state_d == SNOOZE);
    end
  end

  assign bus.alarm_enable = alarm_enable_q;
  assign bus.buzzer       = buzzer_q;
  assign bus.ringing      = ringing_q;
  assign bus.snoozing     = snoozing_q;
  assign bus.snooze_count = snz_cnt_q;
  assign bus.remaining    = remaining_q;

endmodule
